// File: rtl/revo_word_scheduler_if.sv
// Request/word bus between the revo trigger conditioning logic and revo_word_scheduler.
// master drives the trigger-side requests; slave is the scheduler that produces the serdes word.
interface revo_word_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             pll_locked;
  logic             revo_request;
  logic             cal_enable;
  logic             cal_force;
  logic [WIDTH-1:0] word_out;
  logic             cal_active;
  logic             revo_sent;
  logic             revo_dropped;
  logic             cal_aborted;
  logic [15:0]      revo_count;
  logic [15:0]      drop_count;

  modport master (
    output pll_locked, revo_request, cal_enable, cal_force,
    input  word_out, cal_active, revo_sent, revo_dropped, cal_aborted,
           revo_count, drop_count
  );

  modport slave (
    input  pll_locked, revo_request, cal_enable, cal_force,
    output word_out, cal_active, revo_sent, revo_dropped, cal_aborted,
           revo_count, drop_count
  );
endinterface

// File: rtl/revo_word_scheduler.sv
// Word-rate scheduler choosing revo marker, calibration burst or idle word for the serdes.
// Define REVO_WORD_SCHEDULER_COUNTERS_EN to build the saturating revo/drop counters.
module revo_word_scheduler #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD    = 8'b11110000,
  parameter logic [WIDTH-1:0] REVO_WORD    = 8'b11110100,
  parameter logic [WIDTH-1:0] CAL_WORD_A   = 8'b11001100,
  parameter logic [WIDTH-1:0] CAL_WORD_B   = 8'b00110011,
  parameter int               CAL_INTERVAL = 1024,
  parameter int               CAL_LENGTH   = 16,
  parameter int               HOLDOFF      = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  revo_word_scheduler_if.slave bus
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_REVO      = 3'd2;
  localparam logic [2:0] ST_HOLDOFF   = 3'd3;
  localparam logic [2:0] ST_CAL       = 3'd4;

  localparam int IW = $clog2(CAL_INTERVAL);
  localparam int BW = (CAL_LENGTH > 1) ? $clog2(CAL_LENGTH) : 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             cal_active_q, cal_active_d;
  logic             revo_sent_q, revo_sent_d;
  logic             dropped_q, dropped_d;
  logic             aborted_q, aborted_d;
  logic             pending_q, pending_d;
  logic [IW-1:0]    interval_q, interval_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             wrap;
  logic             set_pending;

  // Outputs are computed for the state being entered so that they appear registered
  // in the same cycle as that state; losing lock overrides every other decision.
  always_comb begin
    state_d      = state_q;
    word_d       = IDLE_WORD;
    cal_active_d = 1'b0;
    revo_sent_d  = 1'b0;
    dropped_d    = 1'b0;
    aborted_d    = 1'b0;
    pending_d    = pending_q;
    interval_d   = interval_q;
    burst_d      = burst_q;
    hold_d       = hold_q;
    wrap         = (interval_q == IW'(CAL_INTERVAL - 1));
    set_pending  = 1'b0;

    if (!bus.pll_locked || state_q == ST_WAIT_LOCK) begin
      dropped_d  = bus.revo_request;
      interval_d = '0;
      pending_d  = 1'b0;
      burst_d    = '0;
      hold_d     = '0;
      state_d    = bus.pll_locked ? ST_IDLE : ST_WAIT_LOCK;
    end else begin
      interval_d  = wrap ? '0 : interval_q + IW'(1);
      set_pending = (wrap && bus.cal_enable) || bus.cal_force;
      case (state_q)
        ST_IDLE: begin
          if (bus.revo_request) begin
            state_d = ST_REVO;
          end else if (pending_q) begin
            state_d   = ST_CAL;
            burst_d   = '0;
            pending_d = 1'b0;
          end
        end
        ST_REVO: begin
          dropped_d = bus.revo_request;
          state_d   = ST_HOLDOFF;
          hold_d    = HW'(HOLDOFF);
        end
        ST_HOLDOFF: begin
          dropped_d = bus.revo_request;
          if (hold_q == HW'(1)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        ST_CAL: begin
          if (bus.revo_request) begin
            state_d   = ST_REVO;
            aborted_d = 1'b1;
            burst_d   = '0;
          end else if (burst_q == BW'(CAL_LENGTH - 1)) begin
            state_d = ST_IDLE;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
      if (set_pending) pending_d = 1'b1;
    end

    if (state_d == ST_REVO) begin
      word_d      = REVO_WORD;
      revo_sent_d = 1'b1;
    end else if (state_d == ST_CAL) begin
      word_d       = burst_d[0] ? CAL_WORD_B : CAL_WORD_A;
      cal_active_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_LOCK;
      word_q       <= IDLE_WORD;
      cal_active_q <= 1'b0;
      revo_sent_q  <= 1'b0;
      dropped_q    <= 1'b0;
      aborted_q    <= 1'b0;
      pending_q    <= 1'b0;
      interval_q   <= '0;
      burst_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cal_active_q <= cal_active_d;
      revo_sent_q  <= revo_sent_d;
      dropped_q    <= dropped_d;
      aborted_q    <= aborted_d;
      pending_q    <= pending_d;
      interval_q   <= interval_d;
      burst_q      <= burst_d;
      hold_q       <= hold_d;
    end
  end

`ifdef REVO_WORD_SCHEDULER_COUNTERS_EN
  logic [15:0] revo_cnt_q, drop_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      revo_cnt_q <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (revo_sent_d && revo_cnt_q != 16'hFFFF) revo_cnt_q <= revo_cnt_q + 16'd1;
      if (dropped_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.revo_count = revo_cnt_q;
  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.revo_count = 16'd0;
  assign bus.drop_count = 16'd0;
`endif

  assign bus.word_out     = word_q;
  assign bus.cal_active   = cal_active_q;
  assign bus.revo_sent    = revo_sent_q;
  assign bus.revo_dropped = dropped_q;
  assign bus.cal_aborted  = aborted_q;

endmodule

// File: tb/tb_revo_word_scheduler.sv
// Bench for revo_word_scheduler: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model held in this file.
module tb_revo_word_scheduler;
  localparam int         WIDTH        = 8;
  localparam int         CAL_INTERVAL = 32;
  localparam int         CAL_LENGTH   = 16;
  localparam int         HOLDOFF      = 8;
  localparam logic [7:0] IDLE_W       = 8'b11110000;
  localparam logic [7:0] REVO_W       = 8'b11110100;
  localparam logic [7:0] CAL_A        = 8'b11001100;
  localparam logic [7:0] CAL_B        = 8'b00110011;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  revo_word_scheduler_if #(.WIDTH(WIDTH)) bus ();

  revo_word_scheduler #(
    .WIDTH(WIDTH), .IDLE_WORD(IDLE_W), .REVO_WORD(REVO_W),
    .CAL_WORD_A(CAL_A), .CAL_WORD_B(CAL_B),
    .CAL_INTERVAL(CAL_INTERVAL), .CAL_LENGTH(CAL_LENGTH), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  // model: lock flag, edges spent locked, pending flag, holdoff words left, burst position
  bit          m_locked;
  int          m_lock_cycles;
  bit          m_pending;
  int          m_hold_left;
  int          m_burst_pos;
  bit          m_revo_now;
  logic [7:0]  e_word;
  bit          e_cal_active, e_sent, e_dropped, e_aborted;
  logic [15:0] e_revo_count, e_drop_count;

  task automatic model_reset();
    m_locked = 0; m_lock_cycles = 0; m_pending = 0; m_hold_left = 0;
    m_burst_pos = -1; m_revo_now = 0;
    e_word = IDLE_W; e_cal_active = 0; e_sent = 0; e_dropped = 0; e_aborted = 0;
    e_revo_count = 16'd0; e_drop_count = 16'd0;
  endtask

  task automatic model_step(input bit pl, input bit rr, input bit ce, input bit cf);
    bit wrap, new_req;
    e_sent = 0; e_dropped = 0; e_aborted = 0; e_cal_active = 0; e_word = IDLE_W;
    if (!m_locked || !pl) begin
      e_dropped = rr;
      m_locked = pl; m_lock_cycles = 0; m_pending = 0;
      m_hold_left = 0; m_burst_pos = -1; m_revo_now = 0;
    end else begin
      wrap = (m_lock_cycles % CAL_INTERVAL) == CAL_INTERVAL - 1;
      m_lock_cycles++;
      new_req = (wrap && ce) || cf;
      if (m_revo_now) begin
        m_revo_now = 0; m_hold_left = HOLDOFF; e_dropped = rr;
      end else if (m_hold_left > 0) begin
        e_dropped = rr; m_hold_left--;
      end else if (m_burst_pos >= 0) begin
        if (rr) begin
          e_aborted = 1; m_revo_now = 1; m_burst_pos = -1;
        end else if (m_burst_pos == CAL_LENGTH - 1) m_burst_pos = -1;
        else m_burst_pos++;
      end else begin
        if (rr) m_revo_now = 1;
        else if (m_pending) begin
          m_burst_pos = 0; m_pending = 0;
        end
      end
      if (new_req) m_pending = 1;
      if (m_revo_now) begin
        e_word = REVO_W; e_sent = 1;
        if (e_revo_count != 16'hFFFF) e_revo_count++;
      end else if (m_burst_pos >= 0) begin
        e_word = (m_burst_pos % 2 == 1) ? CAL_B : CAL_A; e_cal_active = 1;
      end
    end
    if (e_dropped && e_drop_count != 16'hFFFF) e_drop_count++;
  endtask

  task automatic check_field(input string tag, input string name,
                             input logic [15:0] obs, input logic [15:0] expv);
    assert_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
    end
  endtask

  task automatic check_output(input string tag);
    logic [15:0] exp_rc, exp_dc;
`ifdef REVO_WORD_SCHEDULER_COUNTERS_EN
    exp_rc = e_revo_count; exp_dc = e_drop_count;
`else
    exp_rc = 16'd0; exp_dc = 16'd0;
`endif
    check_field(tag, "word_out",     {8'd0, bus.word_out},   {8'd0, e_word});
    check_field(tag, "cal_active",   {15'd0, bus.cal_active},   {15'd0, e_cal_active});
    check_field(tag, "revo_sent",    {15'd0, bus.revo_sent},    {15'd0, e_sent});
    check_field(tag, "revo_dropped", {15'd0, bus.revo_dropped}, {15'd0, e_dropped});
    check_field(tag, "cal_aborted",  {15'd0, bus.cal_aborted},  {15'd0, e_aborted});
    check_field(tag, "revo_count",   bus.revo_count, exp_rc);
    check_field(tag, "drop_count",   bus.drop_count, exp_dc);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply_stimulus(input string tag, input bit pl, input bit rr,
                                input bit ce, input bit cf);
    bus.pll_locked = pl; bus.revo_request = rr; bus.cal_enable = ce; bus.cal_force = cf;
    @(posedge clock);
    model_step(pl, rr, ce, cf);
    #1;
    check_output(tag);
    @(negedge clock);
  endtask

  task automatic check_bound(input string tag, input bit reached);
    assert_count++;
    assert (reached) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=timeout expected=condition reached", tag);
    end
  endtask

  initial begin
    int  guard;
    bit  ce_r;
    reset_n = 1'b0;
    bus.pll_locked = 0; bus.revo_request = 0; bus.cal_enable = 0; bus.cal_force = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_output("reset");
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] revo while unlocked");
    apply_stimulus("unlocked_revo", 0, 1, 0, 0);
    apply_stimulus("unlocked_idle", 0, 0, 0, 0);

    $display("[TB] single revo and holdoff");
    apply_stimulus("lock", 1, 0, 0, 0);
    apply_stimulus("revo1", 1, 1, 0, 0);
    repeat (12) apply_stimulus("holdoff1", 1, 0, 0, 0);

    $display("[TB] two revos three cycles apart");
    apply_stimulus("revo2a", 1, 1, 0, 0);
    repeat (2) apply_stimulus("gap2", 1, 0, 0, 0);
    apply_stimulus("revo2b", 1, 1, 0, 0);
    repeat (12) apply_stimulus("holdoff2", 1, 0, 0, 0);

    $display("[TB] periodic calibration");
    repeat (80) apply_stimulus("periodic", 1, 0, 1, 0);

    $display("[TB] revo on fifth burst word");
    guard = 0;
    while (m_burst_pos != 4 && guard < 100) begin
      apply_stimulus("seek_abort", 1, 0, 1, 0);
      guard++;
    end
    check_bound("seek_abort", m_burst_pos == 4);
    apply_stimulus("abort", 1, 1, 0, 0);
    repeat (25) apply_stimulus("after_abort", 1, 0, 0, 0);

    $display("[TB] lock loss mid-burst");
    guard = 0;
    while (m_burst_pos != 5 && guard < 100) begin
      apply_stimulus("seek_unlock", 1, 0, 1, 0);
      guard++;
    end
    check_bound("seek_unlock", m_burst_pos == 5);
    apply_stimulus("unlock", 0, 0, 1, 0);
    repeat (50) apply_stimulus("relock", 1, 0, 1, 0);

    $display("[TB] cal_force coincident with interval wrap");
    guard = 0;
    while (m_lock_cycles % CAL_INTERVAL != CAL_INTERVAL - 1 && guard < 100) begin
      apply_stimulus("seek_wrap", 1, 0, 0, 0);
      guard++;
    end
    check_bound("seek_wrap", m_lock_cycles % CAL_INTERVAL == CAL_INTERVAL - 1);
    apply_stimulus("force_wrap", 1, 0, 1, 1);
    repeat (30) apply_stimulus("single_burst", 1, 0, 0, 0);

    $display("[TB] random traffic");
    ce_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) ce_r = ~ce_r;
      apply_stimulus("random", $urandom_range(63) != 0, $urandom_range(11) == 0,
                     ce_r, $urandom_range(39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
